// File: rtl/baud_gen_pkg.sv
// Shared constants, the phase-width helper and a divisor table for baud_gen.
// The divisor table assumes a 16x oversampled tick at the board clock.
package baud_pkg;

  localparam int BAUD_WIDTH_DEF = 16;
  localparam int BAUD_OSR_DEF   = 16;
  localparam int BOARD_CLK_HZ   = 50_000_000;

  typedef enum logic [0:0] {
    RATE_9600   = 1'b0,
    RATE_115200 = 1'b1
  } baud_rate_e;

  // Tick-rate divisors (TICK period = DIV+1) for each standard rate.
  localparam logic [BAUD_WIDTH_DEF-1:0] DIV_TABLE [2] = '{
    BAUD_WIDTH_DEF'(BOARD_CLK_HZ / (9600 * BAUD_OSR_DEF) - 1),
    BAUD_WIDTH_DEF'(BOARD_CLK_HZ / (115200 * BAUD_OSR_DEF) - 1)
  };

  function automatic int log2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/baud_gen_if.sv
// Control and status bundle of baud_gen. sync/bit_tick exist only when
// BAUD_GEN_OSR_EN is defined.
interface baud_gen_if
  import baud_pkg::*;
#(
  parameter int WIDTH = BAUD_WIDTH_DEF
);

  logic             en;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] o;
  logic             tick;
  logic             baud_out;

`ifdef BAUD_GEN_OSR_EN
  logic sync;
  logic bit_tick;

  modport master (output en, div, sync, input o, tick, baud_out, bit_tick);
  modport slave  (input en, div, sync, output o, tick, baud_out, bit_tick);
`else
  modport master (output en, div, input o, tick, baud_out);
  modport slave  (input en, div, output o, tick, baud_out);
`endif

endinterface

// File: rtl/baud_gen_wrap_counter.sv
// Modulo counter (modulus max_val+1) with enable, priority load and a
// registered one-cycle wrap strobe.
module wrap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] count,
  output logic         wrap
);

  // max_val may only change while count is zero, so count never passes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else if (en && (count == max_val)) begin
      count <= '0;
      wrap  <= 1'b1;
    end else begin
      if (en) count <= count + W'(1);
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/baud_gen.sv
// Programmable baud-rate generator: TICK every DIV+1 enabled cycles plus a
// BAUD_OUT square wave. BAUD_GEN_OSR_EN adds the SYNC-able BIT_TICK stage.
module baud_gen
  import baud_pkg::*;
#(
  parameter int WIDTH = BAUD_WIDTH_DEF,
  parameter int OSR   = BAUD_OSR_DEF
) (
  input logic     clk,
  input logic     reset,
  baud_gen_if.slave bus
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] div_q;
  logic             tick;
  logic             baud_q;
  logic             sync_now;
  logic             wrap_now;

`ifdef BAUD_GEN_OSR_EN
  assign sync_now = bus.sync;
`else
  assign sync_now = 1'b0;
`endif

  assign wrap_now = bus.en && (cnt == div_q) && !sync_now;

  // The shadow divisor only reloads when cnt restarts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= bus.div;
      baud_q <= 1'b0;
    end else if (sync_now || wrap_now) begin
      div_q <= bus.div;
      if (wrap_now) baud_q <= ~baud_q;
    end
  end

  wrap_counter #(.W(WIDTH)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.en),
    .load     (sync_now),
    .load_val ('0),
    .max_val  (div_q),
    .count    (cnt),
    .wrap     (tick)
  );

`ifdef BAUD_GEN_OSR_EN
  localparam int            PW        = log2(OSR);
  localparam logic [PW-1:0] PHASE_MID = PW'(OSR / 2);
  localparam logic [PW-1:0] PHASE_MAX = PW'(OSR - 1);

  logic [PW-1:0] phase;
  logic          bit_tick;

  // SYNC restarts the phase at mid-bit so BIT_TICK samples the bit centre.
  wrap_counter #(.W(PW)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .en       (wrap_now),
    .load     (sync_now),
    .load_val (PHASE_MID),
    .max_val  (PHASE_MAX),
    .count    (phase),
    .wrap     (bit_tick)
  );

  assign bus.bit_tick = bit_tick;
`endif

  assign bus.o        = cnt;
  assign bus.tick     = tick;
  assign bus.baud_out = baud_q;

endmodule

// File: tb/tb_baud_gen.sv
// Directed self-checking bench for baud_gen (16-bit and 4-bit instances);
// the oversampling checks are built only when BAUD_GEN_OSR_EN is defined.
module tb_baud_gen;
  import baud_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  int   assertCount = 0;
  int   failCount = 0;

  int expO3 [8] = '{3, 4, 5, 0, 1, 0, 1, 0};
  int expT3 [8] = '{0, 0, 0, 1, 0, 1, 0, 1};

  baud_gen_if #(.WIDTH(16)) bus ();
  baud_gen_if #(.WIDTH(4))  bus4 ();

  baud_gen #(.WIDTH(16), .OSR(16)) dut (.clk(clk), .reset(rst), .bus(bus));
  baud_gen #(.WIDTH(4), .OSR(16)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));

  always #5 clk = ~clk;

  // Drive one edge's worth of inputs, then land 1 ns after that edge.
  task automatic applyStimulus(input logic rstV, input logic enV, input logic [15:0] divV);
    rst     = rstV;
    bus.en  = enV;
    bus.div = divV;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    bus.en   = 1'b0;
    bus.div  = '0;
    bus4.en  = 1'b0;
    bus4.div = '0;
`ifdef BAUD_GEN_OSR_EN
    bus.sync  = 1'b0;
    bus4.sync = 1'b0;
`endif

    $display("[TB] reset then DIV=3");
    applyStimulus(1'b1, 1'b1, 16'd3);
    checkOutput("rst_o", 32'(bus.o), 0);
    checkOutput("rst_tick", 32'(bus.tick), 0);
    checkOutput("rst_baud", 32'(bus.baud_out), 0);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, 1'b1, 16'd3);
      checkOutput($sformatf("div3_o[%0d]", k), 32'(bus.o), k % 4);
      checkOutput($sformatf("div3_tick[%0d]", k), 32'(bus.tick), 32'(k % 4 == 0));
      checkOutput($sformatf("div3_baud[%0d]", k), 32'(bus.baud_out), (k / 4) % 2);
    end

    $display("[TB] DIV=0");
    applyStimulus(1'b1, 1'b1, 16'd0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b1, 16'd0);
      checkOutput($sformatf("div0_tick[%0d]", k), 32'(bus.tick), 1);
      checkOutput($sformatf("div0_o[%0d]", k), 32'(bus.o), 0);
      checkOutput($sformatf("div0_baud[%0d]", k), 32'(bus.baud_out), k % 2);
    end

    $display("[TB] DIV 5 -> 1 mid-period");
    applyStimulus(1'b1, 1'b1, 16'd5);
    applyStimulus(1'b0, 1'b1, 16'd5);
    applyStimulus(1'b0, 1'b1, 16'd5);
    checkOutput("div5_o_before", 32'(bus.o), 2);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 16'd1);
      checkOutput($sformatf("divchg_o[%0d]", k), 32'(bus.o), expO3[k]);
      checkOutput($sformatf("divchg_tick[%0d]", k), 32'(bus.tick), expT3[k]);
    end

    $display("[TB] DIV=2 with EN gap");
    applyStimulus(1'b1, 1'b1, 16'd2);
    applyStimulus(1'b0, 1'b1, 16'd2);
    checkOutput("gap_o_start", 32'(bus.o), 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 16'd2);
      checkOutput($sformatf("gap_o[%0d]", k), 32'(bus.o), 1);
      checkOutput($sformatf("gap_tick[%0d]", k), 32'(bus.tick), 0);
    end
    applyStimulus(1'b0, 1'b1, 16'd2);
    checkOutput("gap_o_resume", 32'(bus.o), 2);
    checkOutput("gap_tick_resume", 32'(bus.tick), 0);
    applyStimulus(1'b0, 1'b1, 16'd2);
    checkOutput("gap_o_wrap", 32'(bus.o), 0);
    checkOutput("gap_tick_wrap", 32'(bus.tick), 1);

    $display("[TB] WIDTH=4 DIV=15");
    bus4.en  = 1'b1;
    bus4.div = 4'd15;
    rst4     = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'd2);
    checkOutput("w4_rst_o", 32'(bus4.o), 0);
    rst4 = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      applyStimulus(1'b0, 1'b0, 16'd2);
      checkOutput($sformatf("w4_o[%0d]", k), 32'(bus4.o), k % 16);
      checkOutput($sformatf("w4_tick[%0d]", k), 32'(bus4.tick), 32'(k % 16 == 0));
    end

`ifdef BAUD_GEN_OSR_EN
    $display("[TB] OSR=16 SYNC");
    applyStimulus(1'b1, 1'b1, 16'd3);
    bus.sync = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'd3);
    bus.sync = 1'b0;
    checkOutput("sync_o", 32'(bus.o), 0);
    checkOutput("sync_tick", 32'(bus.tick), 0);
    checkOutput("sync_bit", 32'(bus.bit_tick), 0);
    for (int k = 1; k <= 96; k++) begin
      applyStimulus(1'b0, 1'b1, 16'd3);
      checkOutput($sformatf("osr_bit[%0d]", k), 32'(bus.bit_tick), 32'(k == 32 || k == 96));
      checkOutput($sformatf("osr_tick[%0d]", k), 32'(bus.tick), 32'(k % 4 == 0));
    end

    $display("[TB] RESET with SYNC");
    bus.sync = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'd3);
    bus.sync = 1'b0;
    checkOutput("rsync_bit", 32'(bus.bit_tick), 0);
    for (int k = 1; k <= 64; k++) begin
      applyStimulus(1'b0, 1'b1, 16'd3);
      checkOutput($sformatf("rsync_bit[%0d]", k), 32'(bus.bit_tick), 32'(k == 64));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/baud_gen.md
# baud_gen

Parametrised baud-rate generator: the next generation of the fixed 4-bit free-running divider. It divides CLK by a runtime-programmable divisor and produces a single-cycle TICK strobe, a 50 % duty BAUD_OUT square wave and the live count. An optional oversampling stage adds a bit-rate strobe that can be realigned for UART receive. It sits between the board clock and the UART TX/RX blocks.

## Interface
- WIDTH, 16: width of DIV and of the count.
- OSR, 16: oversample ratio; a power of two, ≥ 2. Used only when BAUD_GEN_OSR_EN is defined.
- CLK  in  1: single clock; all state updates on the rising edge.
- RESET  in  1: synchronous, active-high reset.
- EN  in  1: count enable; when low, the generator holds.
- DIV  in  WIDTH: divisor; TICK period is DIV+1 enabled cycles.
- O  out  WIDTH: current count value.
- TICK  out  1: one-cycle strobe at count wrap.
- BAUD_OUT  out  1: toggles on every wrap.
- SYNC  in  1: phase realign. Present only with BAUD_GEN_OSR_EN.
- BIT_TICK  out  1: one-cycle strobe every OSR wraps. Present only with BAUD_GEN_OSR_EN.

## Operation
- Internal state: count `cnt` (WIDTH bits) and shadow divisor `div_q` (WIDTH bits).
- RESET=1 has top priority. It sets cnt=0, TICK=0, BAUD_OUT=0 and BIT_TICK=0, sets phase=0, and loads div_q←DIV.
- EN=1, cnt==div_q (wrap):
  - cnt←0, TICK←1, BAUD_OUT←~BAUD_OUT, div_q←DIV.
- EN=1, cnt≠div_q:
  - cnt←cnt+1, TICK←0.
- EN=0: cnt, div_q and BAUD_OUT hold; TICK←0 and BIT_TICK←0.
- DIV is sampled only at reset, at wrap and at SYNC.
  - A mid-period DIV change takes effect at the next period.
  - Because div_q changes only at those points, cnt can never exceed div_q and never overflows.
- DIV=0: wrap occurs on every enabled cycle. TICK stays high continuously while EN=1, and BAUD_OUT toggles every cycle.
- DIV=2^WIDTH−1: period is 2^WIDTH cycles. The count reaches all-ones and then wraps to 0.
- O always equals cnt.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Latency of TICK:
  - Call the first enabled edge after reset "edge 0".
  - TICK is first high after edge DIV, i.e. after DIV+1 enabled edges.
  - After that, TICK is high for exactly one cycle in every DIV+1 enabled cycles.
- Gaps in EN stretch the period by the number of disabled cycles. Phase is preserved across the gap.
- BAUD_OUT period is 2·(DIV+1) enabled cycles, with edges coincident with TICK.
- Reset asserted mid-period takes effect at the next edge. The next period starts from cnt=0 using the current DIV.

## Configuration
- BAUD_GEN_OSR_EN defined:
  - Adds a phase counter of log2(OSR) bits, which increments on each wrap.
  - When phase wraps from OSR−1 to 0, BIT_TICK←1 in the same cycle that TICK←1. BIT_TICK is 0 in all other cycles.
  - SYNC=1 (and RESET=0), regardless of EN, sets cnt←0, phase←OSR/2, div_q←DIV, TICK←0 and BIT_TICK←0. The first BIT_TICK then lands at mid-bit, OSR/2 wraps later.
  - SYNC and wrap in the same cycle: SYNC wins.
  - RESET and SYNC in the same cycle: RESET wins.
- BAUD_GEN_OSR_EN undefined:
  - The SYNC and BIT_TICK ports and the phase logic do not exist.
  - The OSR parameter is accepted but ignored.

## Structure
- Package baud_pkg holds:
  - Default constants BAUD_WIDTH_DEF=16 and BAUD_OSR_DEF=16.
  - A log2 function for the phase width.
  - A localparam table of divisors for the standard rates (9600, 115200) at the board clock.
- One sub-module: wrap_counter. It is a modulo counter with enable, load/clear, and a registered wrap strobe.
  - Instanced once for cnt, with modulus div_q+1.
  - Instanced once for phase, with modulus OSR.

## Test plan
- Reset, then EN=1, DIV=3: TICK high on cycles 4, 8, 12 after release. O sequence is 1,2,3,0,… BAUD_OUT toggles at each TICK.
- DIV=0, EN=1 for 5 cycles: TICK high all 5 cycles after the first edge. BAUD_OUT alternates 1,0,1,0,1.
- DIV=5 running, change DIV to 1 while cnt=2: the current period completes at cnt=5. Subsequent TICKs are 2 cycles apart.
- DIV=2, EN low for 3 cycles while cnt=1: O holds at 1 and TICK=0 throughout. The next TICK arrives 2 enabled cycles after EN rises.
- WIDTH=4, DIV=15: O counts 0..15 and wraps. TICK appears every 16 cycles with no overflow glitch.
- BAUD_GEN_OSR_EN, OSR=16, DIV=3:
  - Pulse SYNC; the first BIT_TICK comes 8 wraps later (32 cycles), then every 64 cycles.
  - RESET asserted together with SYNC leaves phase=0.
